// File: rtl/neuron_pkg.sv
// Types and widths shared by the neuron datapath blocks
// (back_propper, forward_neuron, back_accumulator_1).
package neuron_pkg;

  localparam int NEURON_W = 32;
  localparam int BP_W     = 64;

  typedef enum logic {ACC, HOLD} bacc_state_t;

  typedef logic signed [BP_W-1:0] bp_t;

endpackage

// File: rtl/back_accumulator_1.sv
// Sums one neuron's fan-out of signed error contributions into a wide error
// term and presents it on a valid/ready output. One sum is in flight at a time.
import neuron_pkg::*;

module back_accumulator_1 #(
  parameter int FAN_OUT = 4,
  parameter int IN_W    = NEURON_W,
  parameter int OUT_W   = BP_W,
  parameter int CNT_W   = $clog2(FAN_OUT + 1)
) (
  input  logic             ba1_clk,
  input  logic             ba1_rst,
  input  logic             ba1_in_valid,
  output logic             ba1_in_ready,
  input  logic [IN_W-1:0]  ba1_bpc,
  input  logic             ba1_flush,
  output logic             ba1_out_valid,
  input  logic             ba1_out_ready,
  output logic [OUT_W-1:0] ba1_bp,
  output logic [CNT_W-1:0] ba1_count
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(FAN_OUT - 1);

  bacc_state_t      state_q;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [OUT_W-1:0] bp_q;
  logic [CNT_W-1:0] count_q;
  logic [OUT_W-1:0] bpc_ext;
  logic             accept;
  logic             close;

  assign ba1_in_ready  = (state_q == ACC) & ~ba1_rst;
  assign ba1_out_valid = (state_q == HOLD);
  assign ba1_bp        = bp_q;
  assign ba1_count     = count_q;

  assign bpc_ext = {{(OUT_W - IN_W){ba1_bpc[IN_W-1]}}, ba1_bpc};

  // acc_d/cnt_d include the beat accepted this cycle, so a flush that
  // coincides with a beat closes the sum with that beat counted.
  // NOTE: every always_comb output gets a value on every path; a missing
  // branch would silently infer a latch.
  always_comb begin
    accept = ba1_in_valid & ba1_in_ready;
    acc_d  = accept ? acc_q + bpc_ext : acc_q;
    cnt_d  = accept ? cnt_q + 1'b1 : cnt_q;
    close  = (state_q == ACC) &
             ((accept & (cnt_q == LAST)) |
              (ba1_flush & ((cnt_q != '0) | accept)));
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge ba1_clk) begin
    if (ba1_rst) begin
      state_q <= ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      bp_q    <= '0;
      count_q <= '0;
    end else begin
      case (state_q)
        ACC: begin
          if (close) begin
            state_q <= HOLD;
            bp_q    <= acc_d;
            count_q <= cnt_d;
            acc_q   <= '0;
            cnt_q   <= '0;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_d;
          end
        end
        HOLD: begin
          if (ba1_out_ready) state_q <= ACC;
        end
        default: state_q <= ACC;
      endcase
    end
  end

endmodule
